// File: rtl/me_unit_pkg.sv
// Shared definitions for the ME pipeline stage: bus widths, field offsets,
// load_op encodings and load extension helpers.
package me_unit_pkg;

    localparam int EX_BUS_W    = 75;
    localparam int WB_BUS_W    = 70;

    localparam int EX_PC_LSB   = 43;
    localparam int EX_GR_WE    = 42;
    localparam int EX_DEST_LSB = 37;
    localparam int EX_ALU_LSB  = 5;
    localparam int EX_RFM      = 4;
    localparam int EX_LOP_LSB  = 1;
    localparam int EX_MREQ     = 0;

    localparam int WB_PC_LSB   = 38;
    localparam int WB_GR_WE    = 37;
    localparam int WB_DEST_LSB = 32;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_op_e;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/me_unit_load_align.sv
// Combinational load-data alignment and sign/zero extension for the ME stage.
module me_load_align
    import me_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/halfword, then extend according to load_op
    always_comb begin
        byte_s = 8'd0;
        half_s = 16'd0;
        result = rdata;
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        // halfword accesses are naturally aligned, so only addr[1] matters
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (load_op)
            LD_W:    result = rdata;
            LD_B:    result = ext_byte(byte_s, 1'b1);
            LD_BU:   result = ext_byte(byte_s, 1'b0);
            LD_H:    result = ext_half(half_s, 1'b1);
            LD_HU:   result = ext_half(half_s, 1'b0);
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/me_unit.sv
// ME pipeline stage: holds one instruction, waits for the data-SRAM response,
// buffers it across WB stalls and forms the WB bus. Optional ME_FWD_EN enables forwarding.
module me_unit
    import me_unit_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                EX_to_ME_Valid,
    input  logic [EX_BUS_W-1:0] EX_to_ME_Bus,
    output logic                ME_Allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic                ME_to_WB_Valid,
    output logic [WB_BUS_W-1:0] ME_to_WB_Bus,
    input  logic                WB_Allow_in,
    output logic [4:0]          ME_dest,
    output logic                ME_fwd_valid,
    output logic [31:0]         ME_fwd_data,
    output logic                ME_load_pending
);

    logic                me_valid_r;
    logic [EX_BUS_W-1:0] payload_r;
    logic                buf_valid_r;
    logic [31:0]         buf_data_r;

    logic [31:0] pc_s;
    logic        gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] alu_result_s;
    logic        res_from_mem_s;
    logic [2:0]  load_op_s;
    logic        mem_req_s;

    logic        resp_seen_s;
    logic        ready_go_s;
    logic        allow_in_s;
    logic        handoff_s;
    logic        buf_capture_s;
    logic [31:0] load_data_s;
    logic [31:0] aligned_s;
    logic [31:0] final_result_s;

    assign pc_s           = payload_r[EX_PC_LSB +: 32];
    assign gr_we_s        = payload_r[EX_GR_WE];
    assign dest_s         = payload_r[EX_DEST_LSB +: 5];
    assign alu_result_s   = payload_r[EX_ALU_LSB +: 32];
    assign res_from_mem_s = payload_r[EX_RFM];
    assign load_op_s      = payload_r[EX_LOP_LSB +: 3];
    assign mem_req_s      = payload_r[EX_MREQ];

    assign resp_seen_s    = data_sram_data_ok || buf_valid_r;
    assign ready_go_s     = !mem_req_s || resp_seen_s;
    assign allow_in_s     = !me_valid_r || (ready_go_s && WB_Allow_in);
    assign handoff_s      = me_valid_r && ready_go_s && WB_Allow_in;
    // a response that cannot be handed on this cycle must survive rdata changing
    assign buf_capture_s  = me_valid_r && mem_req_s && data_sram_data_ok && !WB_Allow_in;
    assign load_data_s    = buf_valid_r ? buf_data_r : data_sram_rdata;

    me_load_align u_align (
        .rdata   (load_data_s),
        .addr    (alu_result_s[1:0]),
        .load_op (load_op_s),
        .result  (aligned_s)
    );

    assign final_result_s  = res_from_mem_s ? aligned_s : alu_result_s;

    assign ME_Allow_in     = allow_in_s;
    assign ME_to_WB_Valid  = me_valid_r && ready_go_s;
    assign ME_to_WB_Bus    = {pc_s, gr_we_s, dest_s, final_result_s};
    assign ME_dest         = (me_valid_r && gr_we_s) ? dest_s : 5'd0;
    assign ME_load_pending = me_valid_r && res_from_mem_s && mem_req_s && !resp_seen_s;

`ifdef ME_FWD_EN
    assign ME_fwd_valid    = me_valid_r && gr_we_s && ready_go_s;
    assign ME_fwd_data     = final_result_s;
`else
    assign ME_fwd_valid    = 1'b0;
    assign ME_fwd_data     = 32'd0;
`endif

    // Stage occupancy and instruction payload capture from EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            me_valid_r <= 1'b0;
            payload_r  <= {EX_BUS_W{1'b0}};
        end else begin
            if (allow_in_s) begin
                me_valid_r <= EX_to_ME_Valid;
            end
            if (EX_to_ME_Valid && allow_in_s) begin
                payload_r <= EX_to_ME_Bus;
            end
        end
    end

    // Response buffer: holds load data while WB is stalled, released on handoff
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'd0;
        end else if (handoff_s) begin
            buf_valid_r <= 1'b0;
        end else if (buf_capture_s) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= data_sram_rdata;
        end
    end

endmodule

// File: tb/tb_me_unit.sv
// Scoreboard bench for me_unit: randomized instruction stream plus directed
// load-alignment, WB-stall buffering and reset-during-load scenarios.
module tb_me_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EX_to_ME_Valid;
    logic [74:0] EX_to_ME_Bus;
    logic        ME_Allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ME_to_WB_Valid;
    logic [69:0] ME_to_WB_Bus;
    logic        WB_Allow_in;
    logic [4:0]  ME_dest;
    logic        ME_fwd_valid;
    logic [31:0] ME_fwd_data;
    logic        ME_load_pending;

    me_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .EX_to_ME_Valid    (EX_to_ME_Valid),
        .EX_to_ME_Bus      (EX_to_ME_Bus),
        .ME_Allow_in       (ME_Allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ME_to_WB_Valid    (ME_to_WB_Valid),
        .ME_to_WB_Bus      (ME_to_WB_Bus),
        .WB_Allow_in       (WB_Allow_in),
        .ME_dest           (ME_dest),
        .ME_fwd_valid      (ME_fwd_valid),
        .ME_fwd_data       (ME_fwd_data),
        .ME_load_pending   (ME_load_pending)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic        rfm;
        logic        gr_we;
        logic [4:0]  dest;
        logic [69:0] bus;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic resp_given = 1'b0;
    bit   mon_en = 1'b0;
    bit   wb_rand = 1'b0;
    logic wb_force = 1'b1;
    exp_t mon_e;
    logic mon_rs;
    logic mon_rdy;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result: shift the addressed lane down, mask, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] op);
        int unsigned b;
        int unsigned h;
        int unsigned sh;
        sh = 8 * int'(a);
        b  = (w >> sh) & 32'hFF;
        sh = 16 * int'(a[1]);
        h  = (w >> sh) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // WB back-pressure: random or forced, changed just after each rising edge
    initial begin
        WB_Allow_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            WB_Allow_in = wb_rand ? ($urandom_range(0, 3) != 0) : wb_force;
        end
    end

    // Monitor: compares the stage outputs against the head-of-queue instruction
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (q.size() == 0) begin
                chk("idle_wb_valid", 70'(ME_to_WB_Valid), 70'(1'b0));
                chk("idle_allow_in", 70'(ME_Allow_in), 70'(1'b1));
                chk("idle_load_pending", 70'(ME_load_pending), 70'(1'b0));
                chk("idle_dest", 70'(ME_dest), 70'(5'd0));
                chk("idle_fwd_valid", 70'(ME_fwd_valid), 70'(1'b0));
            end else begin
                mon_e   = q[0];
                mon_rs  = data_sram_data_ok || resp_given;
                mon_rdy = !mon_e.mem_req || mon_rs;
                chk("wb_valid", 70'(ME_to_WB_Valid), 70'(mon_rdy));
                chk("allow_in", 70'(ME_Allow_in), 70'(mon_rdy && WB_Allow_in));
                chk("load_pending", 70'(ME_load_pending), 70'(mon_e.rfm && mon_e.mem_req && !mon_rs));
                chk("dest", 70'(ME_dest), 70'(mon_e.gr_we ? mon_e.dest : 5'd0));
`ifdef ME_FWD_EN
                chk("fwd_valid", 70'(ME_fwd_valid), 70'(mon_e.gr_we && mon_rdy));
                if (mon_rdy) begin
                    chk("fwd_data", 70'(ME_fwd_data), 70'(mon_e.bus[31:0]));
                end
`else
                chk("fwd_valid", 70'(ME_fwd_valid), 70'(1'b0));
                chk("fwd_data", 70'(ME_fwd_data), 70'(32'd0));
`endif
                if (mon_rdy) begin
                    chk("wb_bus", ME_to_WB_Bus, mon_e.bus);
                    if (WB_Allow_in) begin
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Present one instruction, push its expected WB bus on acceptance, then
    // play the memory response dly cycles after entry (dly < 0: no response)
    task automatic issue(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                         input logic [31:0] alu, input logic rfm, input logic [2:0] lop,
                         input logic mreq, input int dly, input logic [31:0] rd);
        exp_t e;
        int   waited;
        e.mem_req = mreq;
        e.rfm     = rfm;
        e.gr_we   = gr_we;
        e.dest    = dest;
        e.bus     = {pc, gr_we, dest, (rfm ? ref_load(rd, alu[1:0], lop) : alu)};
        EX_to_ME_Bus   = {pc, gr_we, dest, alu, rfm, lop, mreq};
        EX_to_ME_Valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ME_Allow_in && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!ME_Allow_in) begin
            errors++;
            $display("FAIL accept_timeout: allow_in got %b expected 1 after %0d cycles", ME_Allow_in, waited);
        end
        @(posedge clk);
        q.push_back(e);
        resp_given = 1'b0;
        #1;
        EX_to_ME_Valid = 1'b0;
        EX_to_ME_Bus   = 75'({$urandom, $urandom, $urandom});
        if (mreq && dly >= 0) begin
            repeat (dly) begin
                @(posedge clk);
                #1;
            end
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd;
            @(posedge clk);
            resp_given = 1'b1;
            #1;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int kind;
        int waited;
        resetn            = 1'b0;
        EX_to_ME_Valid    = 1'b0;
        EX_to_ME_Bus      = 75'd0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        #22;
        chk("rst_allow_in", 70'(ME_Allow_in), 70'(1'b1));
        chk("rst_wb_valid", 70'(ME_to_WB_Valid), 70'(1'b0));
        chk("rst_wb_bus", ME_to_WB_Bus, 70'd0);
        chk("rst_load_pending", 70'(ME_load_pending), 70'(1'b0));
        chk("rst_dest", 70'(ME_dest), 70'(5'd0));
        chk("rst_fwd", 70'({ME_fwd_valid, ME_fwd_data}), 70'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // single ALU op straight through
        issue(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'd0, 1'b0, 0, 32'd0);
        idle(3);
        // ld.b at byte 3, response two cycles after entry
        issue(32'h1c000004, 1'b1, 5'd6, 32'h00001003, 1'b1, 3'd1, 1'b1, 2, 32'h80FF0000);
        idle(2);
        // ld.hu / ld.h from the upper halfword
        issue(32'h1c000008, 1'b1, 5'd7, 32'h00002002, 1'b1, 3'd4, 1'b1, 1, 32'h80011234);
        issue(32'h1c00000c, 1'b1, 5'd8, 32'h00002002, 1'b1, 3'd3, 1'b1, 0, 32'h80011234);
        idle(2);
        // response arrives under WB stall; rdata then drops to zero
        wb_force = 1'b0;
        idle(1);
        issue(32'h1c000010, 1'b1, 5'd9, 32'h00003000, 1'b1, 3'd0, 1'b1, 0, 32'hA5A5A5A5);
        data_sram_rdata = 32'd0;
        idle(2);
        wb_force = 1'b1;
        idle(1);
        // next load must still wait, i.e. the buffer was released on handoff
        issue(32'h1c000014, 1'b1, 5'd10, 32'h00003001, 1'b1, 3'd2, 1'b1, 2, 32'h00C3B400);
        idle(2);
        // stray response with ME empty and WB stalled must be ignored
        wb_force = 1'b0;
        idle(1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        idle(1);
        data_sram_data_ok = 1'b0;
        wb_force = 1'b1;
        idle(1);
        issue(32'h1c000018, 1'b1, 5'd11, 32'h00003000, 1'b1, 3'd0, 1'b1, 2, 32'h0BADF00D);
        idle(2);
        // back-to-back ALU ops
        for (int i = 0; i < 8; i++) begin
            issue(32'h1c000100 + 32'(4 * i), 1'(i % 2), 5'(i + 1), $urandom, 1'b0, 3'd0, 1'b0, 0, 32'd0);
        end
        idle(3);

        // randomized mix of ALU ops, loads and stores under random WB stalls
        wb_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            issue($urandom, 1'($urandom), 5'($urandom), $urandom,
                  (kind == 1), 3'($urandom_range(0, 4)), (kind != 0),
                  $urandom_range(0, 3), $urandom);
        end
        wb_rand  = 1'b0;
        wb_force = 1'b1;
        idle(3);

        // asynchronous reset while a load waits for its response
        issue(32'h1c000200, 1'b1, 5'd12, 32'h00000004, 1'b1, 3'd0, 1'b1, -1, 32'd0);
        idle(1);
        #2;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("arst_allow_in", 70'(ME_Allow_in), 70'(1'b1));
        chk("arst_wb_valid", 70'(ME_to_WB_Valid), 70'(1'b0));
        chk("arst_wb_bus", ME_to_WB_Bus, 70'd0);
        chk("arst_load_pending", 70'(ME_load_pending), 70'(1'b0));
        chk("arst_dest", 70'(ME_dest), 70'(5'd0));
        chk("arst_fwd", 70'({ME_fwd_valid, ME_fwd_data}), 70'd0);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12121212;
        idle(1);
        data_sram_data_ok = 1'b0;
        idle(3);

        waited = 0;
        while (q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries outstanding, expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/me_unit.md
ME_UNIT -- requirements
Module: me_unit

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous reset, active-low
- EX_to_ME_Valid  in  1  EX has an instruction for this stage
- EX_to_ME_Bus  in  75  pc[74:43], gr_we[42], dest[41:37], alu_result[36:5], res_from_mem[4], load_op[3:1], mem_req[0]
- ME_Allow_in  out  1  stage accepts a new instruction this cycle
- data_sram_data_ok  in  1  load/store response valid, one pulse per issued request
- data_sram_rdata  in  32  response word
- ME_to_WB_Valid  out  1  bus to WB is valid
- ME_to_WB_Bus  out  70  pc[69:38], gr_we[37], dest[36:32], final_result[31:0]
- WB_Allow_in  in  1  WB accepts this cycle
- ME_dest  out  5  dest when ME_Valid and gr_we, else 0
- ME_fwd_valid  out  1  ME_fwd_data is final and forwardable
- ME_fwd_data  out  32  forwarded result
- ME_load_pending  out  1  valid load still waiting for data_ok

Function
REQ-002 SHALL hold one instruction in internal registers; ME_Valid loads EX_to_ME_Valid when ME_Allow_in is high.
REQ-003 SHALL capture EX_to_ME_Bus only when EX_to_ME_Valid && ME_Allow_in.
REQ-004 SHALL compute ME_ReadyGo = !mem_req || resp_seen, where resp_seen = data_sram_data_ok || buf_valid.
REQ-005 SHALL drive ME_Allow_in = !ME_Valid || (ME_ReadyGo && WB_Allow_in).
REQ-006 SHALL drive ME_to_WB_Valid = ME_Valid && ME_ReadyGo.
REQ-007 SHALL capture data_sram_rdata into a 32-bit buffer and set buf_valid when data_ok arrives while ME_Valid && mem_req && !WB_Allow_in.
REQ-008 SHALL clear buf_valid on the cycle the instruction is handed to WB.
REQ-009 SHALL source load data from the buffer when buf_valid is set, else from data_sram_rdata.
REQ-010 SHALL set final_result = aligned load data when res_from_mem, else alu_result.
REQ-011 SHALL align load data by alu_result[1:0]; load_op encoding: 0 ld.w, 1 ld.b, 2 ld.bu, 3 ld.h, 4 ld.hu.
REQ-012 ld.b/ld.h SHALL sign-extend; ld.bu/ld.hu SHALL zero-extend; halfword select SHALL use alu_result[1] only.
REQ-013 Stores (mem_req, !res_from_mem) SHALL wait for data_ok and pass alu_result with gr_we as given.
REQ-014 Non-memory instructions SHALL reach WB with latency 0 cycles after entering ME (single-cycle occupancy).
REQ-015 Loads SHALL occupy ME until the cycle data_ok is seen (or later, if WB stalls).
REQ-016 ME_load_pending SHALL equal ME_Valid && res_from_mem && mem_req && !resp_seen.
REQ-017 ME_fwd_valid SHALL equal ME_Valid && gr_we && ME_ReadyGo; ME_fwd_data SHALL equal final_result.
REQ-018 data_ok received while !ME_Valid or !mem_req SHALL be ignored.
REQ-019 Simultaneous handoff to WB and new capture from EX SHALL both happen in the same cycle, and buf_valid SHALL clear.

Reset
REQ-020 On resetn low (asynchronous), ME_Valid, buf_valid and all payload registers SHALL clear to 0; all outputs SHALL read 0, except ME_Allow_in, which SHALL read 1.
REQ-021 Responses outstanding at reset SHALL be discarded; the memory system is reset together with this block.

Configuration
REQ-022 With ME_FWD_EN defined, ME_dest, ME_fwd_valid and ME_fwd_data SHALL behave per REQ-001/REQ-017.
REQ-023 Without ME_FWD_EN, ME_fwd_valid and ME_fwd_data SHALL be tied 0; ME_dest and ME_load_pending SHALL remain functional so decode can stall on interlocks.

Structure
REQ-024 A shared package SHALL hold bus widths (75, 70), bus field offsets and load_op encodings.
REQ-025 Load alignment and extension SHALL be a combinational sub-module me_load_align (inputs rdata, addr[1:0], load_op; output 32-bit result).

Verification
REQ-026 ALU op, pc=0x1c000000, dest=5, alu_result=0x12345678, WB_Allow_in=1 -> next cycle ME_to_WB_Bus = {0x1c000000, 1, 5, 0x12345678} and ME_to_WB_Valid=1 for exactly one cycle.
REQ-027 ld.b with addr[1:0]=3, data_ok two cycles after entry with rdata=0x80FF0000 -> ME_load_pending=1 for 2 cycles, then final_result=0xFFFFFF80.
REQ-028 ld.hu with addr[1:0]=2, rdata=0x8001_1234 -> final_result=0x00008001; ld.h with the same inputs -> 0xFFFF8001.
REQ-029 data_ok with rdata=0xA5A5A5A5 while WB_Allow_in=0, then rdata changes to 0 and WB_Allow_in rises 3 cycles later -> WB receives 0xA5A5A5A5 and buf_valid clears.
REQ-030 resetn asserted while a load waits -> outputs 0 and ME_Allow_in=1 immediately, asynchronously; a stray data_ok after release produces no ME_to_WB_Valid.
REQ-031 Back-to-back ALU ops with WB_Allow_in=1 -> one instruction handed off per cycle, ME_Allow_in stays 1; build with and without ME_FWD_EN -> ME_fwd_valid toggles or stays 0, respectively.
